// File: rtl/fp_add_pipe.sv
// fp_add_pipe: pipelined sign/exponent/mantissa floating-point adder-subtractor.
// Input register, align, add and normalise stages; one result per clock, latency 3.
module fp_add_pipe #(
  parameter int EW = 6,
  parameter int MW = 12
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          InValid,
  input  logic          Sub,
  input  logic          SignA,
  input  logic          SignB,
  input  logic [EW-1:0] ExponentA,
  input  logic [EW-1:0] ExponentB,
  input  logic [MW-1:0] MantissaA,
  input  logic [MW-1:0] MantissaB,
  output logic          OutValid,
  output logic          SignOut,
  output logic [EW-1:0] ExponentOut,
  output logic [MW-1:0] MantissaOut,
  output logic          Overflow,
  output logic          Underflow,
  output logic          Zero
);
  localparam int LZW = $clog2(MW + 1);
  localparam logic [EW-1:0] EMAX = '1;

  function automatic logic [LZW-1:0] lead_zeros(input logic [MW-1:0] v);
    logic [LZW-1:0] n;
    logic           hit;
    n   = '0;
    hit = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!hit && !v[i]) n = n + LZW'(1);
      else               hit = 1'b1;
    end
    return n;
  endfunction

  // Alignment shifts of MW or more leave nothing of the small mantissa.
  function automatic logic [MW-1:0] align_shift(input logic [MW-1:0] m, input logic [EW-1:0] sh);
    return (32'(sh) >= MW) ? '0 : (m >> sh);
  endfunction

  logic          vld_p0_q, vld_p1_q, vld_p2_q;
  logic          sub_p0_q, sa_p0_q, sb_p0_q;
  logic [EW-1:0] ea_p0_q, eb_p0_q;
  logic [MW-1:0] ma_p0_q, mb_p0_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p0_q <= InValid;
      vld_p1_q <= vld_p0_q;
      vld_p2_q <= vld_p1_q;
    end
  end

  // p0: operand capture
  always_ff @(posedge Clock) begin
    if (InValid) begin
      sub_p0_q <= Sub;
      sa_p0_q  <= SignA;
      sb_p0_q  <= SignB;
      ea_p0_q  <= ExponentA;
      eb_p0_q  <= ExponentB;
      ma_p0_q  <= MantissaA;
      mb_p0_q  <= MantissaB;
    end
  end

  // p0 -> p1: swap so L >= S by magnitude, then align S
  logic          sbe, a_big, sl_d, ss, op_d;
  logic [EW-1:0] el_d, es, diff;
  logic [MW-1:0] ml_d, ms_raw, ms_d;

  always_comb begin
    sbe    = sb_p0_q ^ sub_p0_q;
    a_big  = {ea_p0_q, ma_p0_q} >= {eb_p0_q, mb_p0_q};
    sl_d   = a_big ? sa_p0_q : sbe;
    ss     = a_big ? sbe     : sa_p0_q;
    el_d   = a_big ? ea_p0_q : eb_p0_q;
    es     = a_big ? eb_p0_q : ea_p0_q;
    ml_d   = a_big ? ma_p0_q : mb_p0_q;
    ms_raw = a_big ? mb_p0_q : ma_p0_q;
    diff   = el_d - es;
    ms_d   = align_shift(ms_raw, diff);
    op_d   = sl_d ^ ss;
  end

  logic          sl_p1_q, op_p1_q;
  logic [EW-1:0] el_p1_q;
  logic [MW-1:0] ml_p1_q, ms_p1_q;

  always_ff @(posedge Clock) begin
    sl_p1_q <= sl_d;
    op_p1_q <= op_d;
    el_p1_q <= el_d;
    ml_p1_q <= ml_d;
    ms_p1_q <= ms_d;
  end

  // p1 -> p2: magnitude add/subtract; the swap keeps the difference non-negative
  logic [MW:0] sum_d;

  always_comb begin
    sum_d = op_p1_q ? ({1'b0, ml_p1_q} - {1'b0, ms_p1_q})
                    : ({1'b0, ml_p1_q} + {1'b0, ms_p1_q});
  end

  logic          sl_p2_q;
  logic [EW-1:0] el_p2_q;
  logic [MW:0]   sum_p2_q;

  always_ff @(posedge Clock) begin
    sl_p2_q  <= sl_p1_q;
    el_p2_q  <= el_p1_q;
    sum_p2_q <= sum_d;
  end

  // p2 -> output: normalise with exponent saturation and flush-to-zero
  logic [LZW-1:0] lz;
  logic           so_d, ov_d, uf_d, z_d;
  logic [EW-1:0]  eo_d;
  logic [MW-1:0]  mo_d;

  always_comb begin
    lz   = lead_zeros(sum_p2_q[MW-1:0]);
    so_d = 1'b0;
    eo_d = '0;
    mo_d = '0;
    ov_d = 1'b0;
    uf_d = 1'b0;
    z_d  = 1'b0;
    if (sum_p2_q == '0) begin
      z_d = 1'b1;
    end else if (sum_p2_q[MW]) begin
      so_d = sl_p2_q;
      if (el_p2_q == EMAX) begin
        eo_d = EMAX;
        mo_d = '1;
        ov_d = 1'b1;
      end else begin
        eo_d = el_p2_q + EW'(1);
        mo_d = sum_p2_q[MW:1];
      end
    end else if (32'(el_p2_q) >= 32'(lz)) begin
      so_d = sl_p2_q;
      eo_d = el_p2_q - EW'(lz);
      mo_d = sum_p2_q[MW-1:0] << lz;
    end else begin
      uf_d = 1'b1;
      z_d  = 1'b1;
    end
  end

  logic          vld_p3_q, so_p3_q, ov_p3_q, uf_p3_q, z_p3_q;
  logic [EW-1:0] eo_p3_q;
  logic [MW-1:0] mo_p3_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      vld_p3_q <= 1'b0;
      so_p3_q  <= 1'b0;
      eo_p3_q  <= '0;
      mo_p3_q  <= '0;
      ov_p3_q  <= 1'b0;
      uf_p3_q  <= 1'b0;
      z_p3_q   <= 1'b0;
    end else begin
      vld_p3_q <= vld_p2_q;
      if (vld_p2_q) begin
        so_p3_q <= so_d;
        eo_p3_q <= eo_d;
        mo_p3_q <= mo_d;
        ov_p3_q <= ov_d;
        uf_p3_q <= uf_d;
        z_p3_q  <= z_d;
      end
    end
  end

  assign OutValid    = vld_p3_q;
  assign SignOut     = so_p3_q;
  assign ExponentOut = eo_p3_q;
  assign MantissaOut = mo_p3_q;
  assign Overflow    = ov_p3_q;
  assign Underflow   = uf_p3_q;
  assign Zero        = z_p3_q;

endmodule

// File: tb/tb_fp_add_pipe.sv
// Bench for fp_add_pipe: directed vectors pinned to hand values, random stream with gaps,
// and reset while operations are in flight, all checked against a value-level model.
module tb_fp_add_pipe;
  localparam int EW   = 6;
  localparam int MW   = 12;
  localparam int EMAX = (1 << EW) - 1;

  logic          Clock = 1'b0;
  logic          Reset, InValid, Sub, SignA, SignB;
  logic [EW-1:0] ExponentA, ExponentB, ExponentOut;
  logic [MW-1:0] MantissaA, MantissaB, MantissaOut;
  logic          OutValid, SignOut, Overflow, Underflow, Zero;

  fp_add_pipe #(.EW(EW), .MW(MW)) dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .Sub(Sub),
    .SignA(SignA), .SignB(SignB), .ExponentA(ExponentA), .ExponentB(ExponentB),
    .MantissaA(MantissaA), .MantissaB(MantissaB), .OutValid(OutValid),
    .SignOut(SignOut), .ExponentOut(ExponentOut), .MantissaOut(MantissaOut),
    .Overflow(Overflow), .Underflow(Underflow), .Zero(Zero)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int s; int e; int m; int ov; int uf; int z; int due;
  } res_t;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   run_chk = 1'b0;
  res_t expq[$];
  res_t last;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  // Real-valued view: value = M * 2^E, mantissa window of MW bits, truncating alignment.
  function automatic res_t model(int sub, int sa, int ea, int ma, int sbi, int eb, int mb);
    res_t r;
    int sb, sl, ss, el, ml, es, ms, d, sum, e;
    r  = '{s:0, e:0, m:0, ov:0, uf:0, z:0, due:0};
    sb = sbi ^ sub;
    if (ea * (1 << MW) + ma >= eb * (1 << MW) + mb) begin
      sl = sa; el = ea; ml = ma; ss = sb; es = eb; ms = mb;
    end else begin
      sl = sb; el = eb; ml = mb; ss = sa; es = ea; ms = ma;
    end
    d   = el - es;
    ms  = (d >= MW) ? 0 : (ms >> d);
    sum = (sl == ss) ? ml + ms : ml - ms;
    e   = el;
    if (sum == 0) begin
      r.z = 1;
      return r;
    end
    if (sum >= (1 << MW)) begin
      sum = sum >> 1;
      e   = e + 1;
    end
    while (sum < (1 << (MW - 1))) begin
      sum = sum << 1;
      e   = e - 1;
    end
    if (e > EMAX) begin
      r.s = sl; r.e = EMAX; r.m = (1 << MW) - 1; r.ov = 1;
    end else if (e < 0) begin
      r.uf = 1; r.z = 1;
    end else begin
      r.s = sl; r.e = e; r.m = sum;
    end
    return r;
  endfunction

  function automatic int pack(res_t r);
    return r.m | (r.e << 12) | (r.z << 18) | (r.uf << 19) | (r.ov << 20) | (r.s << 21);
  endfunction

  task automatic drive(input int v, input int sub, input int sa, input int ea, input int ma,
                       input int sb, input int eb, input int mb);
    res_t r;
    @(posedge Clock);
    #2;
    InValid   = v[0];
    Sub       = sub[0];
    SignA     = sa[0];
    ExponentA = EW'(ea);
    MantissaA = MW'(ma);
    SignB     = sb[0];
    ExponentB = EW'(eb);
    MantissaB = MW'(mb);
    if (v != 0) begin
      r     = model(sub, sa, ea, ma, sb, eb, mb);
      r.due = cyc + 4;
      expq.push_back(r);
    end
  endtask

  task automatic vec(input string nm, input int sub, input int sa, input int ea, input int ma,
                     input int sb, input int eb, input int mb,
                     input int xs, input int xe, input int xm, input int xov, input int xuf, input int xz);
    res_t r, x;
    r = model(sub, sa, ea, ma, sb, eb, mb);
    x = '{s:xs, e:xe, m:xm, ov:xov, uf:xuf, z:xz, due:0};
    chk({"model_", nm}, pack(r), pack(x));
    drive(1, sub, sa, ea, ma, sb, eb, mb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge Clock) begin
    res_t r;
    if (run_chk) begin
      if (OutValid) begin
        if (expq.size() == 0) begin
          chk("spurious_valid", int'(OutValid), 0);
        end else begin
          r = expq.pop_front();
          chk("latency",   cyc,               r.due);
          chk("sign",      int'(SignOut),     r.s);
          chk("exponent",  int'(ExponentOut), r.e);
          chk("mantissa",  int'(MantissaOut), r.m);
          chk("overflow",  int'(Overflow),    r.ov);
          chk("underflow", int'(Underflow),   r.uf);
          chk("zero",      int'(Zero),        r.z);
          last = r;
        end
      end else begin
        if (expq.size() > 0 && expq[0].due <= cyc) begin
          chk("missing_valid", int'(OutValid), 1);
          void'(expq.pop_front());
        end
        chk("hold_sign",     int'(SignOut),     last.s);
        chk("hold_exponent", int'(ExponentOut), last.e);
        chk("hold_mantissa", int'(MantissaOut), last.m);
        chk("hold_flags",    int'({Overflow, Underflow, Zero}), (last.ov << 2) | (last.uf << 1) | last.z);
      end
    end
  end

  initial begin
    int n;
    last      = '{s:0, e:0, m:0, ov:0, uf:0, z:0, due:0};
    Reset     = 1'b1;
    InValid   = 1'b0;
    Sub       = 1'b0;
    SignA     = 1'b0;
    SignB     = 1'b0;
    ExponentA = '0;
    ExponentB = '0;
    MantissaA = '0;
    MantissaB = '0;
    repeat (3) @(posedge Clock);
    #2;
    Reset   = 1'b0;
    run_chk = 1'b1;

    // directed vectors, back-to-back
    vec("eq_carry",    0, 0, 10, 'h800, 0, 10, 'h800,  0, 11, 'h800, 0, 0, 0);
    vec("align",       0, 0, 10, 'hC00, 0,  8, 'h800,  0, 10, 'hE00, 0, 0, 0);
    vec("shift_sat",   0, 0, 20, 'h800, 0,  5, 'hFFF,  0, 20, 'h800, 0, 0, 0);
    vec("sub_norm",    1, 0, 10, 'h800, 0, 10, 'h600,  0,  8, 'h800, 0, 0, 0);
    vec("swapped",     0, 1, 10, 'h600, 0, 10, 'h800,  0,  8, 'h800, 0, 0, 0);
    vec("cancel",      1, 0,  7, 'h9A0, 0,  7, 'h9A0,  0,  0, 0,     0, 0, 1);
    vec("overflow",    0, 0, 63, 'h800, 0, 63, 'h800,  0, 63, 'hFFF, 1, 0, 0);
    vec("underflow",   0, 0,  1, 'h800, 1,  1, 'h7FF,  0,  0, 0,     0, 1, 1);
    vec("neg_result",  0, 1, 10, 'hC00, 0,  8, 'h800,  1, 10, 'hA00, 0, 0, 0);
    vec("neg_ovf",     0, 1, 63, 'h800, 1, 63, 'h900,  1, 63, 'hFFF, 1, 0, 0);
    vec("zero_zero",   0, 0,  5, 0,     1,  3, 0,      0,  0, 0,     0, 0, 1);
    vec("unnorm_in",   0, 0,  9, 'h100, 0,  0, 0,      0,  6, 'h800, 0, 0, 0);
    vec("sub_neg_b",   1, 0, 12, 'h800, 1, 12, 'h800,  0, 13, 'h800, 0, 0, 0);
    idle(6);

    // random stream with gaps; garbage operands on idle cycles
    n = 0;
    while (n < 10) begin
      int ea;
      int eb;
      ea = int'($urandom_range(0, EMAX));
      eb = ($urandom_range(0, 1) != 0) ? ea : int'($urandom_range(0, EMAX));
      if ($urandom_range(0, 2) != 0) begin
        drive(1, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), ea, int'($urandom_range(0, 4095)),
              int'($urandom_range(0, 1)), eb, int'($urandom_range(0, 4095)));
        n++;
      end else begin
        drive(0, int'($urandom_range(0, 1)), 1, ea, int'($urandom_range(0, 4095)), 1, eb, int'($urandom_range(0, 4095)));
      end
    end
    idle(6);

    // reset with two operations in flight and a third offered on the reset edge
    drive(1, 0, 0, 30, 'h900, 0, 28, 'hA00);
    drive(1, 1, 0, 40, 'h800, 0, 33, 'hF00);
    @(posedge Clock);
    #2;
    Reset     = 1'b1;
    InValid   = 1'b1;
    ExponentA = 6'd15;
    MantissaA = 12'h800;
    expq.delete();
    @(posedge Clock);
    #2;
    Reset   = 1'b0;
    InValid = 1'b0;
    last    = '{s:0, e:0, m:0, ov:0, uf:0, z:0, due:0};
    idle(6);

    vec("after_reset", 0, 0, 10, 'h800, 0, 10, 'h800,  0, 11, 'h800, 0, 0, 0);
    idle(6);

    chk("queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_add_pipe.md
# fp_add_pipe

Parametrised, fully pipelined sign/exponent/mantissa floating-point adder-subtractor for the neuron datapath. It accumulates weighted products and bias terms. Compared with the single-stage adder it adds:
- configurable exponent and mantissa widths
- a runtime add/subtract mode
- a valid handshake
- post-add normalisation
- exponent overflow/underflow handling with status flags

One result per clock, fixed latency 3.

## Interface
Parameters:
- `EW`, 6, exponent width (unsigned, no special encodings).
- `MW`, 12, mantissa width; explicit leading bit, normalised when `M[MW-1]`=1, zero when `M`=0.

Ports:
- `Clock`  in  1  single clock; all state on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `InValid`  in  1  operands valid this cycle.
- `Sub`  in  1  0 = A+B, 1 = A−B (inverts `SignB` internally).
- `SignA`, `SignB`  in  1  operand signs (1 = negative).
- `ExponentA`, `ExponentB`  in  `EW`  operand exponents.
- `MantissaA`, `MantissaB`  in  `MW`  operand mantissas.
- `OutValid`  out  1  result valid.
- `SignOut`  out  1  result sign.
- `ExponentOut`  out  `EW`  result exponent.
- `MantissaOut`  out  `MW`  result mantissa, normalised unless zero.
- `Overflow`  out  1  exponent saturated this result.
- `Underflow`  out  1  result flushed to zero by exponent underflow.
- `Zero`  out  1  result is exactly zero.

## Operation
- **Stage 1 (align).**
  - Effective `SB = SignB ^ Sub`.
  - Compare magnitudes as `{Exponent, Mantissa}` and swap so L (large) ≥ S (small); on a tie, L = A.
  - `diff = EL − ES`.
  - `MS` is shifted right by `diff`; if `diff ≥ MW`, `MS` becomes 0. Shifted-out bits are discarded (truncation, no rounding).
  - Register L sign/exponent/mantissa, the aligned `MS`, and `op = SignL ^ SB`.
- **Stage 2 (add).**
  - `(MW+1)`-bit result: `op=0` gives `ML + MS`; `op=1` gives `ML − MS`, which is never negative due to the swap.
  - Sign = `SignL`. Register sum, exponent and sign.
- **Stage 3 (normalise), in priority order:**
  - Sum = 0: output 0/0/0 with `SignOut=0`, `Zero=1`. This covers exact cancellation and 0+0.
  - Carry (`sum[MW]`=1): `M = sum[MW:1]`, `E = EL+1`. If `EL` = all-ones, saturate: `E` = all-ones, `M` = all-ones, `Overflow=1`, sign kept.
  - Otherwise compute `lz` = leading zeros of `sum[MW-1:0]`.
    - `EL ≥ lz`: `M = sum << lz`, `E = EL − lz`.
    - `EL < lz`: flush to zero: `SignOut=0`, `E=0`, `M=0`, `Underflow=1`, `Zero=1`.
- **Flags.** Flags are mutually exclusive except `Underflow`+`Zero`. They are valid only with `OutValid`.
- **Input formats.** Unnormalised inputs are accepted and normalised at the output. Zero inputs with any exponent are legal.
- **Valid pipeline.** Valid bits advance every cycle; there is no backpressure or stall.
- **Bubbles.** Stage registers may update on bubbles, but outputs change only on a valid result. When `OutValid=0`, outputs hold their last value.

## Timing
- Operands sampled at edge N with `InValid=1` produce the result and `OutValid=1` after edge N+3. Latency is 3 cycles.
- Throughput is one operation per cycle. Back-to-back inputs give back-to-back outputs, order preserved.
- `OutValid` is high for exactly one cycle per accepted input.
- **Reset.** On a `Reset` edge:
  - `OutValid`, `SignOut`, `ExponentOut`, `MantissaOut`, `Overflow`, `Underflow` and `Zero` all go to 0.
  - All internal valid bits are cleared.
- **Reset mid-operation.** Operations in flight are discarded; no `OutValid` appears for them.
- `InValid` on the reset edge is ignored. The first input accepted is at the first edge with `Reset=0`.
- `Sub` and all operands are sampled only on the edge where `InValid=1`.

## Test plan
(`EW`=6, `MW`=12)
- **Equal-exponent carry:** +E10 M0x800 plus +E10 M0x800, `Sub=0` → E11 M0x800, sign 0, no flags, `OutValid` 3 cycles after input.
- **Alignment and shift saturation:**
  - +E10 M0xC00 plus +E8 M0x800 → E10 M0xE00.
  - +E20 M0x800 plus +E5 M0xFFF (`diff`=15 ≥ `MW`) → E20 M0x800.
- **Subtract with normalise:** +E10 M0x800 minus +E10 M0x600 (`Sub=1`) → sign 0, E8 M0x800. The swapped case −E10 M0x600 plus +E10 M0x800 gives the same result.
- **Cancellation, overflow and underflow:**
  - +E7 M0x9A0 minus +E7 M0x9A0 → `Zero=1`, 0/0/0.
  - +E63 M0x800 plus +E63 M0x800 → E63 M0xFFF, `Overflow=1`.
  - +E1 M0x800 plus −E1 M0x7FF → `Underflow=1`, `Zero=1`, output 0.
- **Streaming and reset:**
  - Ten consecutive random valid inputs with gaps → outputs match a reference model in order, latency exactly 3.
  - `Reset` asserted for one cycle while 2 ops are in flight → no `OutValid` for them; all outputs 0 the cycle after reset.
